// File: rtl/swirl_pkg.sv
// ============================================================================
// Module : swirl_pkg
// Brief  : Shared state encoding, defaults and pattern-fill helper for the
//          LED token swirl driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package swirl_pkg;

  localparam int          DEFAULT_NUM_LEDS = 4;
  localparam int          DEFAULT_TICK_DIV = 12_500_000;
  localparam int unsigned MAX_LEDS         = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_SPIN = 2'd2
  } swirl_state_e;

  // Returns a word with the n lowest bits set; callers cast it to ring width.
  function automatic logic [MAX_LEDS-1:0] fill_low(input int unsigned n);
    logic [MAX_LEDS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_LEDS; i++) begin
      r[i[4:0]] = (i < n);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/swirl_tick_div.sv
// ============================================================================
// Module : swirl_tick_div
// Brief  : Rotation prescaler; emits a one-cycle tick at count TICK_DIV-1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module swirl_tick_div #(
  parameter int TICK_DIV = 12_500_000,
  parameter int DIV_W    = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // clr dominates so a load on a tick cycle restarts the full interval
  always_comb begin
    tick    = en && (count_q == DIV_W'(TICK_DIV - 1));
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/token_swirl_driver.sv
// ============================================================================
// Module : token_swirl_driver
// Brief  : Shows a token count as a contiguous lit group on an LED ring and
//          rotates it at a prescaled rate.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module token_swirl_driver
  import swirl_pkg::*;
#(
  parameter int NUM_LEDS = DEFAULT_NUM_LEDS,
  parameter int CNT_W    = 4,
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int DIV_W    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT_W-1:0]    tok_count,
  input  logic                load,
  input  logic                start,
  input  logic                dir,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic                step_done
);

  swirl_state_e          state_q, state_d;
  logic [NUM_LEDS-1:0]   pattern_q, pattern_d;
  logic                  busy_q, busy_d;
  logic                  step_done_q, step_done_d;

  logic                  spin_run;
  logic                  tick;
  int unsigned           tok_n;
  int unsigned           lit_n;
  logic [NUM_LEDS-1:0]   fill_pat;
  logic [NUM_LEDS-1:0]   rot_pat;

  // Prescaler only runs while actively spinning; any other cycle parks it at 0
  assign spin_run = (state_q == ST_SPIN) && start;

  swirl_tick_div #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (load || !spin_run),
    .en   (spin_run),
    .tick (tick)
  );

  always_comb begin
    tok_n    = 32'(tok_count);
    lit_n    = (tok_n > int'(NUM_LEDS)) ? NUM_LEDS : tok_n;
    fill_pat = NUM_LEDS'(fill_low(lit_n));
    if (dir) begin
      rot_pat = {pattern_q[0], pattern_q[NUM_LEDS-1:1]};
    end else begin
      rot_pat = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    step_done_d = 1'b0;
    if (load) begin
      pattern_d = fill_pat;
      state_d   = start ? ST_SPIN : ST_SHOW;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_SHOW: if (start) state_d = ST_SPIN;
        ST_SPIN: begin
          if (!start) begin
            state_d = ST_SHOW;
          end else if (tick) begin
            pattern_d   = rot_pat;
            step_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_SPIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
    end
  end

  assign led       = pattern_q;
  assign busy      = busy_q;
  assign step_done = step_done_q;

endmodule

`default_nettype wire

// File: tb/tb_token_swirl_driver.sv
// ============================================================================
// Module : tb_token_swirl_driver
// Brief  : Scoreboard bench for token_swirl_driver against a ring/offset model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_token_swirl_driver;

  localparam int N    = 4;
  localparam int TICK = 4;

  localparam int M_IDLE = 0;
  localparam int M_SHOW = 1;
  localparam int M_SPIN = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   tok_count = '0;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic [N-1:0] led;
  logic         busy;
  logic         step_done;

  token_swirl_driver #(
    .NUM_LEDS (N),
    .CNT_W    (4),
    .TICK_DIV (TICK),
    .DIV_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_count (tok_count),
    .load      (load),
    .start     (start),
    .dir       (dir),
    .led       (led),
    .busy      (busy),
    .step_done (step_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: lit count, rotation offset of the group, mode, and cycles spent spinning
  int m_mode  = M_IDLE;
  int m_n     = 0;
  int m_off   = 0;
  int m_phase = 0;
  int m_step  = 0;

  logic [5:0] exp_q[$];
  logic [5:0] exp_v;

  function automatic logic [3:0] model_led(int mode, int n, int off);
    int f;
    int r;
    if (mode == M_IDLE) return 4'b0000;
    f = (1 << n) - 1;
    r = ((f << off) | (f >> (N - off))) & ((1 << N) - 1);
    return r[3:0];
  endfunction

  function automatic logic [5:0] model_out();
    return {model_led(m_mode, m_n, m_off), (m_mode == M_SPIN), (m_step != 0)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_n = 0; m_off = 0; m_phase = 0; m_step = 0;
  endtask

  task automatic drive(input bit r, input bit ld, input bit st, input bit dr, input int tk);
    @(negedge clk);
    rst = r; load = ld; start = st; dir = dr; tok_count = tk[3:0];
    if (r) begin
      model_reset();
    end else if (ld) begin
      m_n     = (tk > N) ? N : tk;
      m_off   = 0;
      m_phase = 0;
      m_step  = 0;
      m_mode  = st ? M_SPIN : M_SHOW;
    end else if (m_mode == M_IDLE) begin
      m_step = 0;
    end else if (m_mode == M_SHOW) begin
      m_step = 0;
      if (st) begin
        m_mode  = M_SPIN;
        m_phase = 0;
      end
    end else if (!st) begin
      m_mode  = M_SHOW;
      m_phase = 0;
      m_step  = 0;
    end else begin
      m_phase++;
      m_step = 0;
      if (m_phase == TICK) begin
        m_phase = 0;
        m_step  = 1;
        m_off   = dr ? (m_off + N - 1) % N : (m_off + 1) % N;
      end
    end
    exp_q.push_back(model_out());
  endtask

  // Reset raised between edges must clear outputs before any clock edge
  task automatic async_reset();
    @(negedge clk);
    load = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({led, busy, step_done} !== 6'b0) begin
      failures++;
      $display("FAIL async_reset got led=%b busy=%b step=%b want 0000/0/0", led, busy, step_done);
    end
    model_reset();
    exp_q.push_back(model_out());
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({led, busy, step_done} !== exp_v) begin
        failures++;
        $display("FAIL out_cycle t=%0t got led=%b busy=%b step=%b want led=%b busy=%b step=%b",
                 $time, led, busy, step_done, exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit st_r;
    bit dr_r;
    bit found;
    #1;
    checks++;
    if ({led, busy, step_done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_state got led=%b busy=%b step=%b want 0000/0/0", led, busy, step_done);
    end
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    drive(0, 1, 1, 0, 3);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0);
    async_reset();
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0);

    drive(0, 1, 0, 0, 2);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 0);

    drive(0, 1, 1, 0, 9);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, 1, 0, 0);

    drive(0, 1, 1, 0, 3);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_mode == M_SPIN && m_phase == TICK - 1) found = 1;
      else drive(0, 0, 1, 0, 0);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL tick_align got no tick cycle want one within 12 cycles");
    end
    drive(0, 1, 1, 0, 1);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 0);

    st_r = 1'b1;
    dr_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) st_r = ~st_r;
      if ($urandom_range(0, 14) == 0) dr_r = ~dr_r;
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        drive(0, ($urandom_range(0, 11) == 0), st_r, dr_r, int'($urandom_range(0, 15)));
      end
    end

    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
